// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter that shares one device bus port between NrHosts hosts.
// It tracks a single outstanding transaction and forces an error response if the device hangs.
module bus_rr_arbiter #(
  parameter int NrHosts       = 3,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        host_req_i    [NrHosts],
  input  logic [AddressWidth-1:0]     host_addr_i   [NrHosts],
  input  logic                        host_we_i     [NrHosts],
  input  logic [3:0]                  host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]        host_wdata_i  [NrHosts],
  output logic                        host_gnt_o    [NrHosts],
  output logic                        host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]        host_rdata_o,
  output logic                        host_err_o,
  output logic                        dev_req_o,
  output logic [AddressWidth-1:0]     dev_addr_o,
  output logic                        dev_we_o,
  output logic [3:0]                  dev_be_o,
  output logic [DataWidth-1:0]        dev_wdata_o,
  input  logic                        dev_rvalid_i,
  input  logic [DataWidth-1:0]        dev_rdata_i,
  input  logic                        dev_err_i,
  output logic                        busy_o,
  output logic [$clog2(NrHosts)-1:0]  owner_o,
  output logic                        timeout_o
);

  localparam int IdxW = $clog2(NrHosts);
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntExpire = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(TimeoutCycles);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              in_wait, resp, expire, window, found, grant;
  logic [IdxW-1:0]   gnt_idx;
  logic [IdxW-1:0]   cand [NrHosts];

  assign in_wait = (state_q == WAIT) && !rst_i;
  assign resp    = in_wait && dev_rvalid_i;
  // The counter reads 0 on the cycle after the grant, so TimeoutCycles-1 marks the expiry cycle.
  assign expire  = in_wait && !dev_rvalid_i && (cnt_q >= CntExpire);
  assign window  = !rst_i && ((state_q == IDLE) || dev_rvalid_i);
  assign grant   = window && found;

  // Scan hosts starting at the priority pointer; the first requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NrHosts; i++) begin
      cand[i] = IdxW'((int'(ptr_q) + i) % NrHosts);
    end
    for (int i = 0; i < NrHosts; i++) begin
      if (!found && host_req_i[cand[i]]) begin
        found   = 1'b1;
        gnt_idx = cand[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      host_gnt_o[i]    = 1'b0;
      host_rvalid_o[i] = 1'b0;
    end
    dev_req_o    = grant;
    dev_addr_o   = '0;
    dev_we_o     = 1'b0;
    dev_be_o     = '0;
    dev_wdata_o  = '0;
    host_rdata_o = '0;
    host_err_o   = 1'b0;
    timeout_o    = 1'b0;

    if (grant) begin
      host_gnt_o[gnt_idx] = 1'b1;
      dev_addr_o          = host_addr_i[gnt_idx];
      dev_we_o            = host_we_i[gnt_idx];
      dev_be_o            = host_be_i[gnt_idx];
      dev_wdata_o         = host_wdata_i[gnt_idx];
    end

    if (resp) begin
      host_rvalid_o[owner_q] = 1'b1;
      host_rdata_o           = dev_rdata_i;
      host_err_o             = dev_err_i;
    end else if (expire) begin
      host_rvalid_o[owner_q] = 1'b1;
      host_err_o             = 1'b1;
      timeout_o              = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant) begin
      state_d = WAIT;
      owner_d = gnt_idx;
      ptr_d   = IdxW'((int'(gnt_idx) + 1) % NrHosts);
      cnt_d   = '0;
    end else if (resp || expire) begin
      state_d = IDLE;
    end else if (in_wait && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register update ordered against the same edge.
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o  = in_wait;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: transaction-level model of hosts and device,
// a response scoreboard drained by an independent monitor, directed cases then random traffic.
module tb_bus_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          host_req_i    [N];
  logic [AW-1:0] host_addr_i   [N];
  logic          host_we_i     [N];
  logic [3:0]    host_be_i     [N];
  logic [DW-1:0] host_wdata_i  [N];
  logic          host_gnt_o    [N];
  logic          host_rvalid_o [N];
  logic [DW-1:0] host_rdata_o;
  logic          host_err_o;
  logic          dev_req_o;
  logic [AW-1:0] dev_addr_o;
  logic          dev_we_o;
  logic [3:0]    dev_be_o;
  logic [DW-1:0] dev_wdata_o;
  logic          dev_rvalid_i;
  logic [DW-1:0] dev_rdata_i;
  logic          dev_err_i;
  logic          busy_o;
  logic [1:0]    owner_o;
  logic          timeout_o;

  bus_rr_arbiter #(
    .NrHosts(N), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i),
    .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur_cyc  = 0;

  // Reference model: one outstanding transaction, age counted in cycles since its grant.
  bit          m_busy  = 0;
  int          m_ptr   = 0;
  int          m_owner = 0;
  int          m_age   = 0;
  int          m_lat   = 0;   // device latency of the outstanding transaction, 0 = never answers
  logic [31:0] m_rdata;
  logic        m_err;

  int          force_lat   = -1;
  bit          force_rd_en = 0;
  logic [31:0] force_rd    = '0;
  logic        force_er    = 1'b0;
  bit          force_read  = 0;
  bit          cont        = 0;   // a granted host immediately issues its next request
  int          req_pct     = 0;
  bit [N-1:0]  clr_mask    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", name, cur_cyc, act, exp);
    end
  endtask

  task automatic new_payload(input int h);
    host_addr_i[h]  = $urandom;
    host_we_i[h]    = force_read ? 1'b0 : 1'($urandom);
    host_be_i[h]    = 4'($urandom);
    host_wdata_i[h] = $urandom;
  endtask

  function automatic int pick_lat();
    int r;
    if (force_lat >= 0) return force_lat;
    r = int'($urandom_range(15));
    if (r == 0) return 0;
    if (r == 1) return TO;
    return 1 + (r % 3);
  endfunction

  // One clock cycle: drive inputs after the edge, predict, compare at the falling edge.
  task automatic do_cycle(input bit rst, input bit [N-1:0] new_req, input bit stray, output int act_k);
    int         k;
    bit         rv, to, win;
    logic [N-1:0] exp_vec, act_vec;
    exp_t       e;
    @(posedge clk_i);
    #1;
    cur_cyc++;
    rst_i = rst;
    for (int h = 0; h < N; h++) begin
      if (clr_mask[h]) begin
        host_req_i[h] = 1'b0;
        if (cont) begin
          host_req_i[h] = 1'b1;
          new_payload(h);
        end
      end
    end
    clr_mask = '0;
    for (int h = 0; h < N; h++) begin
      if (!host_req_i[h] && (new_req[h] || (int'($urandom_range(99)) < req_pct))) begin
        host_req_i[h] = 1'b1;
        new_payload(h);
      end
    end

    if (m_busy) m_age++;
    rv = !rst && m_busy && (m_lat != 0) && (m_age == m_lat);
    to = !rst && m_busy && !rv && (m_age == TO);
    dev_rvalid_i = rv || (stray && !rst && !m_busy);
    dev_rdata_i  = rv ? m_rdata : $urandom;
    dev_err_i    = rv ? m_err : 1'($urandom);
    if (rv || to) begin
      e.host  = m_owner;
      e.rdata = rv ? m_rdata : 32'h0;
      e.err   = rv ? m_err : 1'b1;
      e.to    = to;
      e.cyc   = cur_cyc;
      exp_q.push_back(e);
    end

    win = !rst && (!m_busy || rv);
    k = -1;
    if (win) begin
      for (int i = 0; i < N; i++) begin
        if (k < 0 && host_req_i[(m_ptr + i) % N]) k = (m_ptr + i) % N;
      end
    end

    @(negedge clk_i);
    exp_vec = '0;
    if (k >= 0) exp_vec[k] = 1'b1;
    act_k = -1;
    for (int h = 0; h < N; h++) begin
      act_vec[h] = host_gnt_o[h];
      if (host_gnt_o[h] && act_k < 0) act_k = h;
    end
    check("gnt", act_vec, exp_vec);
    check("dev_req", dev_req_o, k >= 0);
    if (k >= 0) begin
      check("dev_addr", dev_addr_o, host_addr_i[k]);
      check("dev_we", dev_we_o, host_we_i[k]);
      check("dev_be", dev_be_o, host_be_i[k]);
      check("dev_wdata", dev_wdata_o, host_wdata_i[k]);
    end
    check("busy", busy_o, m_busy && !rst);
    if (!rst) check("owner", owner_o, m_owner);

    if (rst) begin
      m_busy  = 0;
      m_ptr   = 0;
      m_owner = 0;
      m_age   = 0;
    end else if (k >= 0) begin
      m_busy      = 1;
      m_owner     = k;
      m_ptr       = (k + 1) % N;
      m_age       = 0;
      m_lat       = pick_lat();
      m_rdata     = force_rd_en ? force_rd : $urandom;
      m_err       = force_rd_en ? force_er : ($urandom_range(7) == 0);
      clr_mask[k] = 1'b1;
    end else if (rv || to) begin
      m_busy = 0;
    end
  endtask

  task automatic drain();
    int  g;
    bit  any;
    for (int i = 0; i < 40; i++) begin
      any = 0;
      for (int h = 0; h < N; h++) any |= host_req_i[h];
      if (!m_busy && !any && clr_mask == '0) break;
      do_cycle(0, '0, 0, g);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a response is due and checks routing.
  logic [N-1:0] mon_rv, mon_exp;
  exp_t         mon_e;
  always @(negedge clk_i) begin
    for (int h = 0; h < N; h++) mon_rv[h] = host_rvalid_o[h];
    if (exp_q.size() > 0 && exp_q[0].cyc == cur_cyc) begin
      mon_e   = exp_q.pop_front();
      mon_exp = '0;
      mon_exp[mon_e.host] = 1'b1;
      check("rsp_rvalid", mon_rv, mon_exp);
      check("rsp_rdata", host_rdata_o, mon_e.rdata);
      check("rsp_err", host_err_o, mon_e.err);
      check("rsp_timeout", timeout_o, mon_e.to);
    end else begin
      check("no_rsp", {mon_rv, host_err_o, timeout_o}, '0);
      check("idle_rdata", host_rdata_o, '0);
    end
  end

  initial begin
    int g;
    for (int h = 0; h < N; h++) begin
      host_req_i[h]   = 1'b0;
      host_addr_i[h]  = '0;
      host_we_i[h]    = 1'b0;
      host_be_i[h]    = '0;
      host_wdata_i[h] = '0;
    end
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;

    repeat (2) do_cycle(1, '0, 0, g);

    // Single read from host 0 answered in one cycle.
    force_lat = 1; force_rd_en = 1; force_rd = 32'hDEADBEEF; force_er = 1'b0; force_read = 1;
    do_cycle(0, 3'b001, 0, g); check("t1_gnt_host0", g, 0);
    do_cycle(0, '0, 0, g);     check("t1_no_gnt", g, -1);
    do_cycle(0, '0, 0, g);
    force_rd_en = 0; force_read = 0;

    // Three hosts requesting continuously against a one-cycle device.
    do_cycle(1, '0, 0, g);
    cont = 1;
    for (int i = 0; i < 6; i++) begin
      do_cycle(0, (i == 0) ? 3'b111 : 3'b000, 0, g);
      check("rr_order", g, i % N);
    end
    cont = 0;
    drain();

    // Host 1 waits behind a three-cycle transaction of host 0.
    do_cycle(1, '0, 0, g);
    force_lat = 3; do_cycle(0, 3'b001, 0, g); check("wait_gnt0", g, 0);
    force_lat = 1; do_cycle(0, 3'b010, 0, g); check("wait_hold1", g, -1);
    do_cycle(0, '0, 0, g); check("wait_hold2", g, -1);
    do_cycle(0, '0, 0, g); check("wait_gnt1", g, 1);
    drain();

    // Hung device: timeout at TO cycles after grant, stray response later is dropped.
    do_cycle(1, '0, 0, g);
    force_lat = 0; do_cycle(0, 3'b001, 0, g); check("to_gnt", g, 0);
    repeat (3) do_cycle(0, '0, 0, g);
    do_cycle(0, '0, 0, g);
    check("to_pulse", timeout_o, 1'b1);
    check("to_rvalid", host_rvalid_o[0], 1'b1);
    check("to_err", host_err_o, 1'b1);
    check("to_rdata", host_rdata_o, '0);
    check("to_no_gnt", g, -1);
    do_cycle(0, '0, 0, g);
    do_cycle(0, '0, 1, g);
    check("stray_dropped", host_rvalid_o[0], 1'b0);
    do_cycle(0, '0, 0, g);

    // Real response on the expiry cycle wins over the timeout.
    do_cycle(1, '0, 0, g);
    force_lat = TO; force_rd_en = 1; force_rd = 32'h12345678; force_er = 1'b0;
    do_cycle(0, 3'b100, 0, g); check("race_gnt2", g, 2);
    repeat (3) do_cycle(0, '0, 0, g);
    do_cycle(0, '0, 0, g);
    check("race_no_timeout", timeout_o, 1'b0);
    check("race_rvalid", host_rvalid_o[2], 1'b1);
    check("race_rdata", host_rdata_o, 32'h12345678);
    check("race_err", host_err_o, 1'b0);
    force_rd_en = 0;
    drain();

    // Reset mid-transaction restores the pointer to host 0.
    do_cycle(1, '0, 0, g);
    force_lat = 3; do_cycle(0, 3'b010, 0, g); check("rst_gnt1", g, 1);
    do_cycle(1, 3'b101, 0, g); check("rst_no_gnt", g, -1);
    force_lat = 1;
    do_cycle(0, '0, 0, g); check("rst_ptr0_first", g, 0);
    do_cycle(0, '0, 0, g); check("rst_then2", g, 2);
    drain();

    // Random traffic with random latencies, hangs, strays and occasional resets.
    force_lat = -1;
    req_pct   = 35;
    for (int i = 0; i < 1500; i++) begin
      do_cycle($urandom_range(199) == 0, '0, $urandom_range(7) == 0, g);
    end
    req_pct = 0;
    drain();
    @(posedge clk_i);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
